// File: rtl/bcd_arb_pkg.sv
// Shared definitions for the BCD converter arbiter: FSM encoding, digit widths
// and the per-requester data width.
package bcd_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int DIGIT_TENS_W = 3;
  localparam int DIGIT_ONES_W = 4;
  localparam int DATA_W       = 6;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_CONV = ST_CONV,
    S_RESP = ST_RESP
  } state_e;

endpackage

// File: rtl/bcd_conv_arbiter_bin6_to_dec.sv
// Combinational 6-bit binary to two-digit decimal converter (0..63).
// The tens digit comes from a compare-against-decades chain.
module bin6_to_dec
  import bcd_arb_pkg::*;
(
  input  logic [DATA_W-1:0]       value,
  output logic [DIGIT_TENS_W-1:0] tens,
  output logic [DIGIT_ONES_W-1:0] ones
);

  // Decade compare chain; the remainder below each decade is the ones digit.
  always_comb begin
    tens = 3'd0;
    ones = 4'd0;
    if (value >= 6'd60) begin
      tens = 3'd6;
      ones = 4'(value - 6'd60);
    end else if (value >= 6'd50) begin
      tens = 3'd5;
      ones = 4'(value - 6'd50);
    end else if (value >= 6'd40) begin
      tens = 3'd4;
      ones = 4'(value - 6'd40);
    end else if (value >= 6'd30) begin
      tens = 3'd3;
      ones = 4'(value - 6'd30);
    end else if (value >= 6'd20) begin
      tens = 3'd2;
      ones = 4'(value - 6'd20);
    end else if (value >= 6'd10) begin
      tens = 3'd1;
      ones = 4'(value - 6'd10);
    end else begin
      tens = 3'd0;
      ones = value[3:0];
    end
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one bin6_to_dec converter among N requesters.
// Define BCD_ARB_STATS_EN to add the conv_count / overflow_seen statistics outputs.
module bcd_conv_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N-1:0]            req_valid,
  input  logic [DATA_W*N-1:0]     req_data,
  output logic [N-1:0]            req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [DIGIT_TENS_W-1:0] rsp_tens,
  output logic [DIGIT_ONES_W-1:0] rsp_ones
`ifdef BCD_ARB_STATS_EN
  ,
  output logic [7:0]              conv_count,
  output logic                    overflow_seen
`endif
);

  state_e                  state_r, state_nxt_s;
  logic [IDW-1:0]          rr_r, id_r, grant_idx_s;
  logic [DATA_W-1:0]       data_r, data_sel_s;
  logic [N-1:0]            low_mask_s, hi_req_s, cand_s, pick_s;
  logic                    take_s, hs_s;
  logic [DIGIT_TENS_W-1:0] conv_tens_s;
  logic [DIGIT_ONES_W-1:0] conv_ones_s;

  // Rotating priority: lowest pending index at or above rr_r, else lowest overall.
  always_comb begin
    low_mask_s  = (N'(1) << rr_r) - N'(1);
    hi_req_s    = req_valid & ~low_mask_s;
    if (|hi_req_s) begin
      cand_s = hi_req_s;
    end else begin
      cand_s = req_valid;
    end
    pick_s      = cand_s & (~cand_s + N'(1));
    grant_idx_s = '0;
    data_sel_s  = '0;
    for (int i = 0; i < N; i++) begin
      grant_idx_s = grant_idx_s | ((((pick_s >> i) & N'(1)) != '0) ? IDW'(i) : IDW'(0));
      data_sel_s  = data_sel_s |
                    ((((pick_s >> i) & N'(1)) != '0) ? DATA_W'(req_data >> (DATA_W * i)) : 6'd0);
    end
  end

  assign take_s = (state_r == S_IDLE) && (|pick_s);
  assign hs_s   = (state_r == S_RESP) && rsp_valid && rsp_ready;

  // Grant is only offered while idle; it is combinational so acceptance is same-cycle.
  always_comb begin
    if (state_r == S_IDLE) begin
      req_ready = pick_s;
    end else begin
      req_ready = '0;
    end
  end

  bin6_to_dec u_conv (
    .value (data_r),
    .tens  (conv_tens_s),
    .ones  (conv_ones_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (take_s) state_nxt_s = S_CONV;
        else        state_nxt_s = S_IDLE;
      end
      S_CONV: state_nxt_s = S_RESP;
      S_RESP: begin
        if (hs_s) state_nxt_s = S_IDLE;
        else      state_nxt_s = S_RESP;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Winner capture, response registers and round-robin pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r    <= '0;
      id_r      <= '0;
      rr_r      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_tens  <= '0;
      rsp_ones  <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (take_s) begin
            data_r <= data_sel_s;
            id_r   <= grant_idx_s;
          end
        end
        S_CONV: begin
          rsp_tens  <= conv_tens_s;
          rsp_ones  <= conv_ones_s;
          rsp_id    <= id_r;
          rsp_valid <= 1'b1;
        end
        S_RESP: begin
          if (hs_s) begin
            rsp_valid <= 1'b0;
            rr_r      <= (id_r == IDW'(N - 1)) ? '0 : id_r + IDW'(1);
          end
        end
        default: rsp_valid <= 1'b0;
      endcase
    end
  end

`ifdef BCD_ARB_STATS_EN
  // Saturating handshake counter; overflow_seen is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_count    <= 8'd0;
      overflow_seen <= 1'b0;
    end else if (hs_s) begin
      if (conv_count == 8'd255) overflow_seen <= 1'b1;
      else                      conv_count    <= conv_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter: directed scenarios plus randomized
// traffic against a behavioural round-robin / divide-by-ten model.
module tb_bcd_conv_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int DW  = 6 * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [DW-1:0] req_data = '0;
  logic [N-1:0]  req_ready;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [IDW-1:0] rsp_id;
  logic [2:0]    rsp_tens;
  logic [3:0]    rsp_ones;
`ifdef BCD_ARB_STATS_EN
  logic [7:0]    conv_count;
  logic          overflow_seen;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  bcd_conv_arbiter #(.N(N), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_tens  (rsp_tens),
    .rsp_ones  (rsp_ones)
`ifdef BCD_ARB_STATS_EN
    ,
    .conv_count    (conv_count),
    .overflow_seen (overflow_seen)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_data(input int i, input int v);
    logic [5:0] v6;
    v6 = 6'(v);
    req_data = (req_data & ~(DW'(6'h3F) << (6 * i))) | (DW'(v6) << (6 * i));
  endtask

  function automatic int get_data(input int i);
    logic [5:0] v6;
    v6 = 6'(req_data >> (6 * i));
    return int'(v6);
  endfunction

  // Reference arbitration: first pending index at or after rr, wrapping.
  function automatic int model_grant(input logic [N-1:0] pend, input int rr);
    logic [N-1:0] sh;
    for (int k = 0; k < N; k++) begin
      sh = pend >> ((rr + k) % N);
      if (sh[0]) return (rr + k) % N;
    end
    return -1;
  endfunction

  task automatic test_reset();
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_tens, rsp_ones} !== '0)
      $display("FAIL reset_async got=%h exp=0", {req_ready, rsp_valid, rsp_id, rsp_tens, rsp_ones});
    else n_pass++;
    do_reset();
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_tens, rsp_ones} !== '0)
      $display("FAIL reset_release got=%h exp=0", {req_ready, rsp_valid, rsp_id, rsp_tens, rsp_ones});
    else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    set_data(0, 59);
    req_valid = 4'b0001;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) $display("FAIL single_grant got=%b exp=0001", req_ready);
    else n_pass++;
    cyc();
    req_valid = '0;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL single_early_valid got=%b exp=0", rsp_valid);
    else n_pass++;
    cyc();
    #1;
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_tens, rsp_ones} !== {1'b1, 2'd0, 3'd5, 4'd9})
      $display("FAIL single_result got v=%b id=%0d t=%0d o=%0d exp v=1 id=0 t=5 o=9",
               rsp_valid, rsp_id, rsp_tens, rsp_ones);
    else n_pass++;
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    #1;
    n_checks++;
    if ({rsp_valid, rsp_tens, rsp_ones} !== {1'b0, 3'd5, 4'd9})
      $display("FAIL single_after_hs got v=%b t=%0d o=%0d exp v=0 t=5 o=9", rsp_valid, rsp_tens, rsp_ones);
    else n_pass++;
  endtask

  task automatic test_all_four();
    int exp_id[4] = '{0, 1, 2, 3};
    int exp_t[4]  = '{6, 0, 1, 4};
    int exp_o[4]  = '{3, 0, 0, 2};
    int got = 0, served = 0, last_gc = 0;
    logic [N-1:0] granted;
    do_reset();
    set_data(0, 63); set_data(1, 0); set_data(2, 10); set_data(3, 42);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int c = 0; c < 40 && served < 4; c++) begin
      #1;
      granted = req_ready;
      if (req_ready !== '0) begin
        n_checks++;
        if (got >= 4 || req_ready !== (N'(1) << exp_id[got]))
          $display("FAIL all4_grant idx=%0d got=%b", got, req_ready);
        else n_pass++;
        if (got > 0) begin
          n_checks++;
          if (c - last_gc !== 3) $display("FAIL all4_spacing got=%0d exp=3", c - last_gc);
          else n_pass++;
        end
        last_gc = c;
        got++;
      end
      if (rsp_valid && rsp_ready) begin
        n_checks++;
        if (served >= 4 || rsp_id !== IDW'(exp_id[served]) || rsp_tens !== 3'(exp_t[served]) ||
            rsp_ones !== 4'(exp_o[served]) || c - last_gc !== 2)
          $display("FAIL all4_rsp n=%0d got id=%0d t=%0d o=%0d lat=%0d", served, rsp_id, rsp_tens,
                   rsp_ones, c - last_gc);
        else n_pass++;
        served++;
      end
      cyc();
      req_valid = req_valid & ~granted;
    end
    n_checks++;
    if (served !== 4) $display("FAIL all4_done got=%0d exp=4", served);
    else n_pass++;
  endtask

  task automatic test_fairness();
    int got = 0;
    do_reset();
    set_data(0, int'($urandom_range(63)));
    set_data(2, int'($urandom_range(63)));
    req_valid = 4'b0101;
    rsp_ready = 1'b1;
    for (int c = 0; c < 40 && got < 6; c++) begin
      #1;
      if (req_ready !== '0) begin
        n_checks++;
        if (req_ready !== ((got % 2 == 0) ? 4'b0001 : 4'b0100))
          $display("FAIL rr_alternate n=%0d got=%b", got, req_ready);
        else n_pass++;
        got++;
      end
      cyc();
    end
    n_checks++;
    if (got !== 6) $display("FAIL rr_grant_count got=%0d exp=6", got);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    set_data(1, 37);
    set_data(2, int'($urandom_range(63)));
    req_valid = 4'b0110;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) $display("FAIL bp_grant got=%b exp=0010", req_ready);
    else n_pass++;
    cyc();
    req_valid = 4'b0100;
    cyc();
    for (int k = 0; k < 10; k++) begin
      #1;
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_tens, rsp_ones, req_ready} !== {1'b1, 2'd1, 3'd3, 4'd7, 4'b0000})
        $display("FAIL bp_hold k=%0d got v=%b id=%0d t=%0d o=%0d rdy=%b", k, rsp_valid, rsp_id,
                 rsp_tens, rsp_ones, req_ready);
      else n_pass++;
      cyc();
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    #1;
    n_checks++;
    if ({rsp_valid, rsp_tens, rsp_ones, req_ready} !== {1'b0, 3'd3, 4'd7, 4'b0100})
      $display("FAIL bp_release got v=%b t=%0d o=%0d rdy=%b exp v=0 t=3 o=7 rdy=0100",
               rsp_valid, rsp_tens, rsp_ones, req_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid_resp();
    do_reset();
    set_data(1, int'($urandom_range(63)));
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    cyc();
    req_valid = '0;
    cyc();
    cyc();
    rsp_ready = 1'b0;
    set_data(3, int'($urandom_range(63)));
    req_valid = 4'b1000;
    cyc();
    req_valid = '0;
    cyc();
    #1;
    n_checks++;
    if ({rsp_valid, rsp_id} !== {1'b1, 2'd3}) $display("FAIL rst_pre got v=%b id=%0d exp v=1 id=3", rsp_valid, rsp_id);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_tens, rsp_ones} !== '0)
      $display("FAIL rst_async got=%h exp=0", {req_ready, rsp_valid, rsp_id, rsp_tens, rsp_ones});
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    set_data(0, int'($urandom_range(63)));
    req_valid = 4'b1001;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({req_ready, rsp_valid} !== {4'b0001, 1'b0})
      $display("FAIL rst_rr_restart got rdy=%b v=%b exp rdy=0001 v=0", req_ready, rsp_valid);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [N-1:0] granted, bit_m, exp_rr;
    int rr_m = 0, g, gc = 0, exp_id = 0, exp_v = 0;
    bit busy = 1'b0;
    do_reset();
    granted = '0;
    for (int c = 0; c < 500; c++) begin
      req_valid = req_valid & ~granted;
      for (int i = 0; i < N; i++) begin
        bit_m = N'(1) << i;
        if ((req_valid & bit_m) == '0) begin
          if ($urandom_range(3) == 0) begin
            set_data(i, int'($urandom_range(63)));
            req_valid = req_valid | bit_m;
          end
        end else if ($urandom_range(19) == 0) begin
          req_valid = req_valid & ~bit_m;
        end
      end
      rsp_ready = ($urandom_range(2) != 0);
      #1;
      g = busy ? -1 : model_grant(req_valid, rr_m);
      exp_rr = (g < 0) ? '0 : (N'(1) << g);
      n_checks++;
      if (req_ready !== exp_rr) $display("FAIL rnd_grant c=%0d got=%b exp=%b", c, req_ready, exp_rr);
      else n_pass++;
      n_checks++;
      if (rsp_valid !== (busy && (c - gc) >= 2))
        $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, rsp_valid, busy && (c - gc) >= 2);
      else n_pass++;
      if (busy && rsp_valid) begin
        n_checks++;
        if (rsp_id !== IDW'(exp_id) || rsp_tens !== 3'(exp_v / 10) || rsp_ones !== 4'(exp_v % 10))
          $display("FAIL rnd_data c=%0d got id=%0d t=%0d o=%0d exp id=%0d t=%0d o=%0d", c, rsp_id,
                   rsp_tens, rsp_ones, exp_id, exp_v / 10, exp_v % 10);
        else n_pass++;
        if (rsp_ready) begin
          rr_m = (exp_id + 1) % N;
          busy = 1'b0;
        end
      end
      granted = req_ready;
      if (g >= 0) begin
        busy   = 1'b1;
        gc     = c;
        exp_id = g;
        exp_v  = get_data(g);
      end
      cyc();
    end
  endtask

`ifdef BCD_ARB_STATS_EN
  task automatic test_stats();
    int hs = 0;
    bit hs_now;
    do_reset();
    set_data(0, 17);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    for (int c = 0; c < 900 && hs < 256; c++) begin
      #1;
      hs_now = rsp_valid && rsp_ready;
      if (hs_now) hs++;
      cyc();
      if (hs_now) begin
        n_checks++;
        if (conv_count !== 8'((hs > 255) ? 255 : hs) || overflow_seen !== (hs > 255))
          $display("FAIL stats n=%0d got cnt=%0d ovf=%b", hs, conv_count, overflow_seen);
        else n_pass++;
      end
    end
    n_checks++;
    if (hs !== 256) $display("FAIL stats_hs_count got=%0d exp=256", hs);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_backpressure();
    test_reset_mid_resp();
    test_random();
`ifdef BCD_ARB_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
- Shares one 6-bit binary-to-decimal converter (tens digit 0..6, ones digit 0..9) among N requesters.
- Round-robin arbitration; per-requester valid/ready request handshake; single valid/ready response channel tagged with requester ID.
- Sits between the switch/counter sources and the seven-segment display drivers, so only one converter instance is built per board.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, 2, width of requester ID; must satisfy 2**IDW >= N.

Ports:
- Clock  input  1  system clock, rising edge.
- Resetn  input  1  asynchronous active-low reset.
- req_valid  input  N  request pending, one bit per requester.
- req_data  input  6*N  binary values; requester i on bits [6i+5:6i].
- req_ready  output  N  one-hot acceptance pulse; at most one bit high per cycle.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  IDW  index of the requester that owns the result.
- rsp_tens  output  3  decimal tens digit.
- rsp_ones  output  4  decimal ones digit.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_id=0, rsp_tens=0, rsp_ones=0, state=IDLE, rr pointer=0.
- Reset is asynchronous and takes effect mid-operation. Any held result is dropped and no response is emitted for it.
- Default value is 0 wherever the state list below is silent.
- States: IDLE, CONV, RESP; 2-bit encoding.
- IDLE:
  - If any req_valid bit is set, pick the first set bit at or after the rr pointer, searching upward and wrapping from N-1 to 0.
  - Assert req_ready for that bit combinationally in the same cycle. A transfer occurs when req_valid && req_ready.
  - Latch the winner's 6-bit data and ID; go to CONV.
  - No request pending: stay in IDLE.
- CONV: register the converter outputs into rsp_tens/rsp_ones, set rsp_valid=1, set rsp_id to the latched ID; go to RESP.
- RESP:
  - Hold rsp_* stable while rsp_ready=0. Backpressure is unbounded; req_ready stays 0 throughout.
  - On rsp_valid && rsp_ready: clear rsp_valid, set rr pointer to (winner+1) mod N, go to IDLE.
  - Digits are held at their last value after the handshake.
- Latency:
  - Request accepted in cycle T; rsp_valid=1 in cycle T+2.
  - Peak throughput is one result per 3 cycles, with rsp_ready tied high.
- Arithmetic: tens = v/10, ones = v%10. The full input range 0..63 is valid, with no saturation.
- Simultaneous requests: exactly one is granted per IDLE cycle. Losers keep req_valid high and are served in rr order. No requester waits more than N grants.
- Requester deasserts req_valid before being granted: no effect, request is not served.
- req_data of non-granted requesters is ignored.

Optional Feature:
- Macro: BCD_ARB_STATS_EN.
- Defined:
  - Adds output conv_count (8 bits), reset to 0.
  - Increments on each response handshake and saturates at 255.
  - Adds output overflow_seen (1 bit): set when a handshake occurs while conv_count==255, cleared only by reset.
- Undefined: neither port exists and there is no extra logic. Core timing is identical in both builds.

Decomposition:
- Shared package bcd_arb_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_CONV=2'd1, ST_RESP=2'd2;
  - constant DIGIT_TENS_W=3;
  - constant DIGIT_ONES_W=4.
- Sub-module bin6_to_dec, purely combinational: 6-bit value in, tens[2:0] and ones[3:0] out. Instantiated once in the arbiter; tens logic is the existing 6-bit compare-to-decades equation set.

Test Plan:
- Reset, then a single request: req_valid=4'b0001, data0=6'd59 → req_ready=0001 in cycle T; rsp_valid in T+2 with id=0, tens=5, ones=9.
- All four requesters valid together (data 63, 0, 10, 42), rsp_ready tied high → served in order id 0,1,2,3 with results (6,3), (0,0), (1,0), (4,2), spaced 3 cycles apart.
- Round-robin fairness: req 0 and req 2 held high continuously → grants alternate 0,2,0,2; req 0 is never granted twice in a row.
- Backpressure: rsp_ready=0 for 10 cycles while holding a result of 37 → rsp_valid, id, tens=3, ones=7 stay stable and req_ready stays 0; release rsp_ready → handshake, then the next grant follows.
- Reset mid-RESP: drop Resetn while rsp_valid=1 → all outputs go to 0 asynchronously; after release, the rr pointer restarts at 0 (req 3 and req 0 pending → req 0 granted first).
- BCD_ARB_STATS_EN defined: 256 back-to-back conversions → conv_count=255, overflow_seen=1; with the macro undefined, the build has no such ports.
